// File: rtl/frame_ram_writer_pkg.sv
// Shared definitions for the frame store write path: FSM encoding and default image geometry.
// The frame reader uses the same state names and geometry.
package frame_ram_writer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_WRITE    = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   localparam int IMG_WIDTH        = 256;
   localparam int IMG_HEIGHT       = 256;
   localparam int DEF_DATA_WIDTH   = 24;
   localparam int DEF_ADDR_WIDTH   = 16;
   localparam int DEF_FRAME_PIXELS = IMG_WIDTH * IMG_HEIGHT;

   // States in which the writer takes pixel beats from the stream.
   function automatic logic is_active(input state_t s);
      return (s == ST_WAIT_SOF) || (s == ST_WRITE);
   endfunction

endpackage

// File: rtl/frame_ram_writer.sv
// Write side of the frame store: takes the filtered pixel stream and writes one frame
// sequentially into a single-port RAM at addresses 0..FRAME_PIXELS-1.
module frame_ram_writer
   import frame_ram_writer_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
   input  logic                  clk,
   input  logic                  tb_rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic                  s_sof,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sof_err,
   output logic [ADDR_WIDTH:0]   pix_cnt
);

   // Handshake: a beat transfers on a rising edge where s_valid & s_ready; s_ready is a
   // decode of the state register only and never looks at s_valid.

   localparam int                CNT_W    = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

   state_t           state, state_nx;
   logic             accept;
   logic             wr_beat;
   logic             resync;
   logic             last_beat;
   logic [CNT_W-1:0] beat_idx;

   assign s_ready = is_active(state);
   assign busy    = is_active(state);
   assign done    = (state == ST_DONE);

   always_comb begin
      accept    = s_valid & s_ready & ~abort;
      wr_beat   = 1'b0;
      resync    = 1'b0;
      // An SOF beat always restarts the frame at address 0.
      beat_idx  = s_sof ? '0 : pix_cnt;
      if (accept) begin
         case (state)
            ST_WAIT_SOF: wr_beat = s_sof;
            ST_WRITE: begin
               wr_beat = 1'b1;
               resync  = s_sof && (pix_cnt != '0);
            end
            default: wr_beat = 1'b0;
         endcase
      end
      last_beat = wr_beat && (beat_idx == LAST_IDX);
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:     if (start) state_nx = ST_WAIT_SOF;
         ST_WAIT_SOF: if (wr_beat) state_nx = last_beat ? ST_DONE : ST_WRITE;
         ST_WRITE:    if (last_beat) state_nx = ST_DONE;
         ST_DONE:     state_nx = ST_IDLE;
         default:     state_nx = ST_IDLE;
      endcase
      if (abort) state_nx = ST_IDLE;
   end

   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Registered write port; pix_cnt is left alone on abort so it can be inspected afterwards.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         pix_cnt <= '0;
         sof_err <= 1'b0;
      end else begin
         wr_en <= wr_beat;
         if (wr_beat) begin
            wr_addr <= beat_idx[ADDR_WIDTH-1:0];
            wr_data <= s_data;
            pix_cnt <= beat_idx + CNT_W'(1);
         end
         if (state == ST_IDLE && start && !abort) begin
            pix_cnt <= '0;
            sof_err <= 1'b0;
         end
         if (resync) sof_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_frame_ram_writer.sv
// Bench for frame_ram_writer: 16-pixel frames through a table of scenarios, hand-written
// abort/reset sequences, plus a full 65536-pixel frame and a single-pixel frame.
module tb_frame_ram_writer;
   import frame_ram_writer_pkg::*;

   localparam int AW = 4;
   localparam int DW = 24;
   localparam int FP = 16;

   logic          clk;
   logic          tb_rst;
   logic          start, start_big, start_one;
   logic          abort;
   logic          s_valid, s_sof;
   logic [DW-1:0] s_data;

   logic          s_ready, wr_en, busy, done, sof_err;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [AW:0]   pix_cnt;

   logic          s_ready_b, wr_en_b, busy_b, done_b, sof_err_b;
   logic [15:0]   wr_addr_b;
   logic [DW-1:0] wr_data_b;
   logic [16:0]   pix_cnt_b;

   logic          s_ready_o, wr_en_o, busy_o, done_o, sof_err_o;
   logic [0:0]    wr_addr_o;
   logic [DW-1:0] wr_data_o;
   logic [1:0]    pix_cnt_o;

   frame_ram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_PIXELS(FP)) dut (
      .clk(clk), .tb_rst(tb_rst), .start(start), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .sof_err(sof_err), .pix_cnt(pix_cnt)
   );

   frame_ram_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(DW), .FRAME_PIXELS(65536)) dut_big (
      .clk(clk), .tb_rst(tb_rst), .start(start_big), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready_b), .s_sof(s_sof), .s_data(s_data),
      .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .busy(busy_b), .done(done_b), .sof_err(sof_err_b), .pix_cnt(pix_cnt_b)
   );

   frame_ram_writer #(.ADDR_WIDTH(1), .DATA_WIDTH(DW), .FRAME_PIXELS(1)) dut_one (
      .clk(clk), .tb_rst(tb_rst), .start(start_one), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready_o), .s_sof(s_sof), .s_data(s_data),
      .wr_en(wr_en_o), .wr_addr(wr_addr_o), .wr_data(wr_data_o),
      .busy(busy_o), .done(done_o), .sof_err(sof_err_o), .pix_cnt(pix_cnt_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [AW+DW-1:0] exp_q[$];
   logic [DW-1:0]    ram [0:FP-1];
   int writes_seen = 0;
   int done_seen   = 0;
   int m_cnt       = 0;
   bit m_armed     = 0;

   int          big_writes = 0, big_bad = 0, big_done = 0, big_next = 0;
   logic [15:0] big_last_addr = '0;
   logic        big_done_wr = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (wr_en) begin
         writes_seen++;
         ram[wr_addr] = wr_data;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     wr_addr, wr_data);
         end else begin
            chk("write_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
         end
      end
      if (done) begin
         done_seen++;
         chk("done_with_last_write", 32'({wr_en, wr_addr}), 32'({1'b1, 4'hF}));
      end
      if (wr_en_b) begin
         big_writes++;
         if (int'(wr_addr_b) != big_next || wr_data_b != {8'h5A, wr_addr_b}) big_bad++;
         big_next++;
      end
      if (done_b) begin
         big_done++;
         big_last_addr = wr_addr_b;
         big_done_wr   = wr_en_b;
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a falling edge; returns at the falling edge after the beat was taken.
   task automatic send_beat(input logic [DW-1:0] d, input logic sof);
      int guard = 0;
      s_valid = 1'b1;
      s_sof   = sof;
      s_data  = d;
      while (!s_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!s_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: got s_ready 0, expected 1 within 20 cycles");
         s_valid = 1'b0;
         return;
      end
      if (sof) begin
         m_cnt   = 0;
         m_armed = 1'b1;
      end
      if (m_armed) begin
         exp_q.push_back({m_cnt[AW-1:0], d});
         m_cnt++;
         if (m_cnt == FP) m_armed = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      s_valid = 1'b0;
      s_sof   = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start   = 1'b1;
      m_armed = 1'b0;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // ---------------- table-driven frames ----------------
   typedef struct {
      bit gaps;
      int junk;
      int sof_at;
      bit rand_data;
      bit exp_err;
      int exp_pix;
      int exp_writes;
   } vec_t;

   vec_t vecs[5];

   task automatic run_vector(input vec_t v, input int idx);
      int w0, d0, seg_len, segs;
      logic [DW-1:0] d, first_d, last_d;
      w0 = writes_seen;
      d0 = done_seen;
      first_d = '0;
      last_d  = '0;
      pulse_start();
      chk($sformatf("v%0d_start_pix_cnt", idx), 32'(pix_cnt), 0);
      chk($sformatf("v%0d_start_sof_err", idx), 32'(sof_err), 0);
      chk($sformatf("v%0d_start_ready", idx), 32'({s_ready, busy}), 32'(2'b11));
      for (int j = 0; j < v.junk; j++) begin
         send_beat(24'hAAAAAA, 1'b0);
         if (v.gaps) idle_cycle();
      end
      segs = (v.sof_at >= 0) ? 2 : 1;
      for (int s = 0; s < segs; s++) begin
         seg_len = (s == 0 && v.sof_at >= 0) ? v.sof_at : FP;
         for (int i = 0; i < seg_len; i++) begin
            d = v.rand_data ? 24'($urandom_range(0, 32'hFFFFFF)) : 24'(i);
            if (i == 0) first_d = d;
            last_d = d;
            send_beat(d, i == 0);
            if (v.gaps) idle_cycle();
         end
      end
      repeat (3) idle_cycle();
      chk($sformatf("v%0d_write_count", idx), 32'(writes_seen - w0), 32'(v.exp_writes));
      chk($sformatf("v%0d_done_pulses", idx), 32'(done_seen - d0), 1);
      chk($sformatf("v%0d_pix_cnt", idx), 32'(pix_cnt), 32'(v.exp_pix));
      chk($sformatf("v%0d_sof_err", idx), 32'(sof_err), 32'(v.exp_err));
      chk($sformatf("v%0d_ram0", idx), 32'(ram[0]), 32'(first_d));
      chk($sformatf("v%0d_ram15", idx), 32'(ram[FP-1]), 32'(last_d));
      chk($sformatf("v%0d_queue_empty", idx), 32'(exp_q.size()), 0);
      chk($sformatf("v%0d_idle_ready", idx), 32'({s_ready, busy, done}), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int w0, d0;
      tb_rst = 1'b1;
      start = 1'b0; start_big = 1'b0; start_one = 1'b0; abort = 1'b0;
      s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
      for (int i = 0; i < FP; i++) ram[i] = '0;

      vecs[0] = '{0, 0, -1, 0, 0, 16, 16};
      vecs[1] = '{1, 0, -1, 0, 0, 16, 16};
      vecs[2] = '{0, 3, -1, 1, 0, 16, 16};
      vecs[3] = '{0, 0,  5, 1, 1, 16, 21};
      vecs[4] = '{1, 2, -1, 1, 0, 16, 16};

      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'({s_ready, wr_en, busy, done, sof_err}), 0);
      chk("reset_addr_data", 32'({wr_addr, wr_data}), 0);
      chk("reset_pix_cnt", 32'(pix_cnt), 0);
      tb_rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 5; k++) run_vector(vecs[k], k);

      // abort after 7 writes; the beat presented with abort must not be written
      w0 = writes_seen;
      d0 = done_seen;
      pulse_start();
      for (int i = 0; i < 7; i++) send_beat(24'h000100 + 24'(i), i == 0);
      s_valid = 1'b1; s_sof = 1'b0; s_data = 24'hBADBAD; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; s_valid = 1'b0;
      chk("abort_ready_busy", 32'({s_ready, busy}), 0);
      repeat (2) idle_cycle();
      chk("abort_pix_cnt", 32'(pix_cnt), 7);
      chk("abort_no_done", 32'(done_seen - d0), 0);
      chk("abort_writes", 32'(writes_seen - w0), 7);
      chk("abort_queue_empty", 32'(exp_q.size()), 0);

      // start and abort together: abort wins
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_stays_idle", 32'(busy), 0);
      chk("start_abort_pix_kept", 32'(pix_cnt), 7);
      pulse_start();
      chk("restart_clears_pix_cnt", 32'(pix_cnt), 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_from_wait_sof", 32'(busy), 0);

      // reset after 9 writes: outputs clear at once, RAM keeps its contents
      pulse_start();
      for (int i = 0; i < 9; i++) send_beat(24'h000200 + 24'(i), i == 0);
      s_valid = 1'b0;
      #2 tb_rst = 1'b1;
      #1;
      chk("midreset_outputs", 32'({s_ready, wr_en, busy, done, sof_err}), 0);
      chk("midreset_addr_data", 32'({wr_addr, wr_data}), 0);
      chk("midreset_pix_cnt", 32'(pix_cnt), 0);
      for (int i = 0; i < 9; i++)
         chk($sformatf("ram_retained_%0d", i), 32'(ram[i]), 32'(24'h000200 + 24'(i)));
      chk("midreset_queue_empty", 32'(exp_q.size()), 0);
      m_armed = 1'b0;
      @(negedge clk);
      tb_rst = 1'b0;
      @(negedge clk);
      run_vector(vecs[0], 5);

      // single-pixel frame: the SOF beat goes straight to DONE
      start_one = 1'b1;
      @(negedge clk);
      start_one = 1'b0;
      chk("one_ready", 32'(s_ready_o), 1);
      s_valid = 1'b1; s_sof = 1'b1; s_data = 24'h123456;
      @(negedge clk);
      s_valid = 1'b0; s_sof = 1'b0;
      chk("one_done", 32'(done_o), 1);
      chk("one_write", 32'({wr_en_o, wr_addr_o, wr_data_o}), 32'({1'b1, 1'b0, 24'h123456}));
      chk("one_pix_cnt", 32'(pix_cnt_o), 1);
      @(negedge clk);
      chk("one_after", 32'({done_o, busy_o, wr_en_o, sof_err_o}), 0);

      // full 256x256 frame on the 16-bit address instance
      start_big = 1'b1;
      @(negedge clk);
      start_big = 1'b0;
      chk("big_ready", 32'(s_ready_b), 1);
      for (int i = 0; i < 65536; i++) begin
         s_valid = 1'b1;
         s_sof   = (i == 0);
         s_data  = {8'h5A, 16'(i)};
         @(negedge clk);
      end
      s_valid = 1'b0; s_sof = 1'b0;
      repeat (3) @(negedge clk);
      chk("big_writes", 32'(big_writes), 65536);
      chk("big_order_data_errors", 32'(big_bad), 0);
      chk("big_done_pulses", 32'(big_done), 1);
      chk("big_last_addr", 32'({big_done_wr, big_last_addr}), 32'({1'b1, 16'hFFFF}));
      chk("big_pix_cnt", 32'(pix_cnt_b), 65536);
      chk("big_idle", 32'({busy_b, sof_err_b}), 0);
      chk("main_untouched_queue", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
